// File: rtl/dac_soft_mute.sv
// dac_soft_mute: applies one common Q1.15 gain to every lane of a packed DAC bus.
// The gain ramps linearly between mute (0) and unity (0x8000), so enabling or
// disabling a DAC never produces a step. force_mute is an immediate hard mute.
// Datapath latency is a fixed 2 clocks: multiply, then rescale.
module dac_soft_mute #(
  parameter int unsigned NUMBER_OF_LINE = 8,
  parameter int unsigned RAMP_STEP      = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [16*NUMBER_OF_LINE-1:0]  dac_data_in,
  input  logic                          enable,
  input  logic                          force_mute,
  output logic [16*NUMBER_OF_LINE-1:0]  dac_data_out,
  output logic [15:0]                   gain,
  output logic                          muted,
  output logic                          active
);

  typedef enum logic [1:0] {
    ST_MUTED     = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ACTIVE    = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [15:0] UNITY16 = 16'h8000;
  localparam logic [16:0] UNITY17 = 17'h08000;
  localparam logic [16:0] STEP17  = 17'(RAMP_STEP);
  localparam logic [15:0] STEP16  = 16'(RAMP_STEP);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_gain;
  logic [15:0] w_gain_next;
  logic [16:0] w_up_sum;
  logic [15:0] w_gain_up;
  logic [15:0] w_gain_dn;

  // Saturating ramp steps: up clamps at unity, down clamps at zero; g never wraps.
  always_comb begin
    w_up_sum  = {1'b0, r_gain} + STEP17;
    w_gain_up = (w_up_sum > UNITY17) ? UNITY16 : w_up_sum[15:0];
    w_gain_dn = (r_gain > STEP16) ? (r_gain - STEP16) : '0;
  end

  // State and gain registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_MUTED;
      r_gain  <= '0;
    end else begin
      r_state <= w_state_next;
      r_gain  <= w_gain_next;
    end
  end

  // Next state and next gain; force_mute overrides everything.
  always_comb begin
    w_state_next = r_state;
    w_gain_next  = r_gain;
    if (force_mute) begin
      w_state_next = ST_MUTED;
      w_gain_next  = '0;
    end else begin
      case (r_state)
        ST_MUTED: begin
          w_gain_next = '0;
          if (enable) w_state_next = ST_RAMP_UP;
        end
        ST_RAMP_UP: begin
          if (!enable) begin
            // Reversal steps down immediately from the current gain.
            w_state_next = ST_RAMP_DOWN;
            w_gain_next  = w_gain_dn;
          end else begin
            w_gain_next = w_gain_up;
            if (w_gain_up == UNITY16) w_state_next = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (!enable) w_state_next = ST_RAMP_DOWN;
        end
        ST_RAMP_DOWN: begin
          if (enable) begin
            w_state_next = ST_RAMP_UP;
            w_gain_next  = w_gain_up;
          end else begin
            w_gain_next = w_gain_dn;
            if (w_gain_dn == '0) w_state_next = ST_MUTED;
          end
        end
        default: begin
          w_state_next = ST_MUTED;
          w_gain_next  = '0;
        end
      endcase
    end
  end

  // Status outputs decode the registered state directly, so they carry no extra delay.
  always_comb begin
    gain   = r_gain;
    muted  = (r_state == ST_MUTED);
    active = (r_state == ST_ACTIVE);
  end

  // Per-lane two-stage scaler: y = floor(x * g / 32768).
  for (genvar i = 0; i < NUMBER_OF_LINE; i++) begin : g_lane
    logic signed [32:0] w_x_ext;
    logic signed [32:0] w_g_ext;
    logic signed [32:0] w_prod;
    logic signed [32:0] r_prod;
    logic        [15:0] r_out;
    logic               w_unused_prod_bits;

    assign w_x_ext = {{17{dac_data_in[16*i+15]}}, dac_data_in[16*i +: 16]};
    assign w_g_ext = {17'b0, r_gain};
    assign w_prod  = w_x_ext * w_g_ext;

    // Stage 1: full-precision signed product with the gain of the same cycle.
    always_ff @(posedge clock) begin
      if (reset) r_prod <= '0;
      else       r_prod <= w_prod;
    end

    // Stage 2: arithmetic >>> 15; bits [30:15] always fit because |x*g| <= 2^30.
    always_ff @(posedge clock) begin
      if (reset) r_out <= '0;
      else       r_out <= r_prod[30:15];
    end

    assign dac_data_out[16*i +: 16] = r_out;
    assign w_unused_prod_bits       = ^{r_prod[32:31], r_prod[14:0]};
  end

endmodule

// File: tb/tb_dac_soft_mute.sv
// Self-checking bench for dac_soft_mute: two instances (ramp step 32 and 100)
// driven with the same stimulus, each compared against a gain/settle model and a
// floor(x*g/32768) data model through per-instance scoreboards.
module tb_dac_soft_mute;

  localparam int NL = 8;
  localparam int W  = 16 * NL;

  typedef struct {
    logic [W-1:0] data;
    logic [15:0]  gain;
    logic         muted;
    logic         active;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, en, fm;
  logic [W-1:0] din;
  logic [W-1:0] dout0, dout1;
  logic [15:0]  gain0, gain1;
  logic         muted0, muted1, active0, active1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dac_soft_mute #(.NUMBER_OF_LINE(NL), .RAMP_STEP(32)) dut0 (
    .clock(clk), .reset(rst), .dac_data_in(din), .enable(en), .force_mute(fm),
    .dac_data_out(dout0), .gain(gain0), .muted(muted0), .active(active0)
  );

  dac_soft_mute #(.NUMBER_OF_LINE(NL), .RAMP_STEP(100)) dut1 (
    .clock(clk), .reset(rst), .dac_data_in(din), .enable(en), .force_mute(fm),
    .dac_data_out(dout1), .gain(gain1), .muted(muted1), .active(active1)
  );

  // Reference model: gain value, whether it rests at an endpoint, last ramp direction.
  int           m_gain[2]    = '{0, 0};
  bit           m_settled[2] = '{1'b1, 1'b1};
  bit           m_dir[2]     = '{1'b0, 1'b0};
  int           m_step[2]    = '{32, 100};
  logic [W-1:0] m_p1[2]      = '{'0, '0};
  logic [W-1:0] m_p2[2]      = '{'0, '0};
  exp_t         q0[$];
  exp_t         q1[$];

  function automatic logic [15:0] scale(input logic [15:0] x, input int g);
    int xi, p, q;
    xi = int'($signed(x));
    p  = xi * g;
    q  = p / 32768;
    if (p < 0 && q * 32768 != p) q = q - 1;
    return q[15:0];
  endfunction

  task automatic model_edge(input int d);
    logic [W-1:0] np1;
    int g;
    g = m_gain[d];
    for (int i = 0; i < NL; i++) np1[16*i +: 16] = scale(din[16*i +: 16], g);
    if (rst) begin
      m_p1[d] = '0;
      m_p2[d] = '0;
    end else begin
      m_p2[d] = m_p1[d];
      m_p1[d] = np1;
    end
    if (rst || fm) begin
      m_gain[d] = 0; m_settled[d] = 1'b1; m_dir[d] = 1'b0;
    end else if (m_settled[d]) begin
      if (g == 0 && en)          begin m_settled[d] = 1'b0; m_dir[d] = 1'b1; end
      else if (g == 32768 && !en) begin m_settled[d] = 1'b0; m_dir[d] = 1'b0; end
    end else begin
      if (en) m_gain[d] = (g + m_step[d] > 32768) ? 32768 : g + m_step[d];
      else    m_gain[d] = (g - m_step[d] < 0) ? 0 : g - m_step[d];
      if (en == m_dir[d]) m_settled[d] = en ? (m_gain[d] == 32768) : (m_gain[d] == 0);
      m_dir[d] = en;
    end
  endtask

  function automatic exp_t expected(input int d);
    exp_t e;
    e.data   = m_p2[d];
    e.gain   = 16'(m_gain[d]);
    e.muted  = m_settled[d] && (m_gain[d] == 0);
    e.active = m_settled[d] && (m_gain[d] == 32768);
    return e;
  endfunction

  task automatic tick(input bit r, input bit e, input bit f, input logic [W-1:0] d);
    rst = r; en = e; fm = f; din = d;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    q0.push_back(expected(0));
    q1.push_back(expected(1));
    #1;
  endtask

  function automatic logic [W-1:0] rnd_bus();
    logic [W-1:0] b;
    for (int i = 0; i < NL; i++) begin
      case ($urandom_range(0, 7))
        0: b[16*i +: 16] = 16'h8000;
        1: b[16*i +: 16] = 16'h7FFF;
        2: b[16*i +: 16] = 16'hFFFF;
        3: b[16*i +: 16] = 16'h0001;
        default: b[16*i +: 16] = 16'($urandom);
      endcase
    end
    return b;
  endfunction

  function automatic logic [W-1:0] fill_bus(input logic [15:0] v);
    logic [W-1:0] b;
    for (int i = 0; i < NL; i++) b[16*i +: 16] = v;
    return b;
  endfunction

  // Drive enable until the step-32 model reaches tgt (and rests there if need_settled).
  task automatic run_until(input bit e, input int tgt, input bit need_settled,
                           input bit const_data, input string name);
    int k;
    k = 0;
    while (!(m_gain[0] == tgt && (!need_settled || m_settled[0])) && k < 3000) begin
      tick(1'b0, e, 1'b0, const_data ? fill_bus(16'h4000) : rnd_bus());
      k++;
    end
    checks++;
    if (k >= 3000) begin
      errors++;
      $display("FAIL timeout_%s: model gain %0d, required %0d", name, m_gain[0], tgt);
    end
  endtask

  task automatic compare(input int d, input exp_t e, input logic [W-1:0] ad,
                         input logic [15:0] ag, input logic am, input logic aa);
    checks += 4;
    if (ag !== e.gain) begin
      errors++;
      $display("FAIL gain[dut%0d] t=%0t: got %0d, expected %0d", d, $time, ag, e.gain);
    end
    if (am !== e.muted) begin
      errors++;
      $display("FAIL muted[dut%0d] t=%0t: got %b, expected %b", d, $time, am, e.muted);
    end
    if (aa !== e.active) begin
      errors++;
      $display("FAIL active[dut%0d] t=%0t: got %b, expected %b", d, $time, aa, e.active);
    end
    if (ad !== e.data) begin
      errors++;
      $display("FAIL data[dut%0d] t=%0t: got %h, expected %h", d, $time, ad, e.data);
    end
  endtask

  // Monitor: outputs are valid every cycle; pop one expectation per instance per cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      compare(0, e, dout0, gain0, muted0, active0);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      compare(1, e, dout1, gain1, muted1, active1);
    end
  end

  initial begin
    logic [W-1:0] fs;
    for (int i = 0; i < NL; i++) begin
      case (i % 4)
        0: fs[16*i +: 16] = 16'h8000;
        1: fs[16*i +: 16] = 16'h7FFF;
        2: fs[16*i +: 16] = 16'hFFFF;
        default: fs[16*i +: 16] = 16'h0001;
      endcase
    end

    // Reset state
    repeat (3) tick(1'b1, 1'b0, 1'b0, rnd_bus());
    repeat (3) tick(1'b0, 1'b0, 1'b0, rnd_bus());

    // Ramp up to unity with constant 0x4000 on all lanes, then let it settle
    run_until(1'b1, 32768, 1'b1, 1'b1, "ramp_up");
    repeat (4) tick(1'b0, 1'b1, 1'b0, fill_bus(16'h4000));

    // Full-scale patterns at unity, then random data
    repeat (4) tick(1'b0, 1'b1, 1'b0, fs);
    repeat (20) tick(1'b0, 1'b1, 1'b0, rnd_bus());

    // Down to mute, up to half, reverse while presenting -1 at g = 0x4000
    run_until(1'b0, 0, 1'b1, 1'b0, "ramp_down");
    run_until(1'b1, 16384, 1'b0, 1'b0, "to_half");
    tick(1'b0, 1'b0, 1'b0, fill_bus(16'hFFFF));
    run_until(1'b0, 0, 1'b1, 1'b0, "reverse_down");
    run_until(1'b1, 8000, 1'b0, 1'b0, "partial_up");
    repeat (50) tick(1'b0, 1'b0, 1'b0, rnd_bus());
    run_until(1'b1, 32768, 1'b1, 1'b0, "resume_up");

    // Hard mute from ACTIVE, held against enable, then released
    repeat (10) tick(1'b0, 1'b1, 1'b1, rnd_bus());
    run_until(1'b1, 32768, 1'b1, 1'b0, "after_force");

    // Reset mid-ramp at g = 20000
    run_until(1'b0, 0, 1'b1, 1'b0, "pre_reset_down");
    run_until(1'b1, 20000, 1'b0, 1'b0, "to_20000");
    tick(1'b1, 1'b1, 1'b0, rnd_bus());
    repeat (10) tick(1'b0, 1'b1, 1'b0, rnd_bus());

    // Random control and data
    en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      bit r, f, e;
      e = ($urandom_range(0, 99) < 2) ? ~en : en;
      f = ($urandom_range(0, 199) == 0);
      r = ($urandom_range(0, 599) == 0);
      tick(r, e, f, rnd_bus());
    end

    repeat (3) tick(1'b0, 1'b0, 1'b0, rnd_bus());
    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
